up_down_counter_fsm: RTL and testbench



---
 rtl/up_down_counter_pkg.sv | 30 +++
 rtl/up_down_counter_fsm_edge_detect.sv | 27 ++
 rtl/up_down_counter_fsm.sv | 75 +++++++
 tb/tb_up_down_counter_fsm.sv | 139 +++++++++++++
 4 files changed

// File: rtl/up_down_counter_pkg.sv
// Shared types and constants for the occupancy counter FSM.
package up_down_counter_pkg;

    localparam int unsigned COUNT_W           = 3;
    localparam int unsigned MAX_COUNT_DEFAULT = 7;

    typedef enum logic [COUNT_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } state_t;

    // Bit i set when state index i lies in 0..max_count.
    function automatic logic [(1 << COUNT_W)-1:0] valid_mask(input int unsigned max_count);
        logic [(1 << COUNT_W)-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < (1 << COUNT_W); i++) begin
            if (i <= max_count) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/up_down_counter_fsm_edge_detect.sv
// Rising-edge pulse generator for the Up and Down request lines.
module updown_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic up,
    input  logic down,
    output logic up_pulse,
    output logic down_pulse
);

    logic up_q;
    logic down_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            up_q   <= up;
            down_q <= down;
        end
    end

    assign up_pulse   = up & ~up_q;
    assign down_pulse = down & ~down_q;

endmodule

// File: rtl/up_down_counter_fsm.sv
// Occupancy counter core: Moore FSM, one state per count value, with full/empty/alarm.
// Define UPDOWN_EDGE_DETECT_EN to count only 0->1 transitions of Up/Down.
module up_down_counter_fsm
    import up_down_counter_pkg::*;
#(
    parameter int unsigned MAX_COUNT = MAX_COUNT_DEFAULT
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               Up,
    input  logic               Down,
    output logic [COUNT_W-1:0] Pcount,
    output logic               Full_Flag,
    output logic               Empty_Flag,
    output logic               Alarm_Flag
);

    localparam logic [COUNT_W-1:0]        MAX_IDX = MAX_COUNT[COUNT_W-1:0];
    localparam logic [(1<<COUNT_W)-1:0]   VALID   = valid_mask(MAX_COUNT);

    state_t state;
    logic   alarm;
    logic   up_req;
    logic   down_req;

`ifdef UPDOWN_EDGE_DETECT_EN
    updown_edge_detect u_edge (
        .clk        (CLK),
        .reset      (reset),
        .up         (Up),
        .down       (Down),
        .up_pulse   (up_req),
        .down_pulse (down_req)
    );
`else
    assign up_req   = Up;
    assign down_req = Down;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= S0;
            alarm <= 1'b0;
        end else if (!VALID[state]) begin
            // Encodings above MAX_COUNT are unreachable; recover silently.
            state <= S0;
            alarm <= 1'b0;
        end else begin
            alarm <= 1'b0;
            case ({up_req, down_req})
                2'b10: begin
                    if (state == state_t'(MAX_IDX)) begin
                        alarm <= 1'b1;
                    end else begin
                        state <= state_t'(state + 3'd1);
                    end
                end
                2'b01: begin
                    if (state == S0) begin
                        alarm <= 1'b1;
                    end else begin
                        state <= state_t'(state - 3'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Pcount     = state;
    assign Full_Flag  = (state == state_t'(MAX_IDX));
    assign Empty_Flag = (state == S0);
    assign Alarm_Flag = alarm;

endmodule

// File: tb/tb_up_down_counter_fsm.sv
// Directed scoreboard bench for up_down_counter_fsm (both configurations).
module tb_up_down_counter_fsm;

    localparam int MAX = 7;

    typedef struct packed {
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       alarm;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       up;
    logic       down;
    logic [2:0] pcount;
    logic       full_flag;
    logic       empty_flag;
    logic       alarm_flag;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    // Reference model state
    int   m_cnt   = 0;
    logic m_alarm = 1'b0;
    logic m_pu    = 1'b0;
    logic m_pd    = 1'b0;

    up_down_counter_fsm #(.MAX_COUNT(MAX)) dut (
        .CLK        (clk),
        .reset      (reset),
        .Up         (up),
        .Down       (down),
        .Pcount     (pcount),
        .Full_Flag  (full_flag),
        .Empty_Flag (empty_flag),
        .Alarm_Flag (alarm_flag)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model(input logic r, input logic u, input logic d);
        logic ru, rd;
        if (r) begin
            m_cnt = 0; m_alarm = 1'b0; m_pu = 1'b0; m_pd = 1'b0;
        end else begin
`ifdef UPDOWN_EDGE_DETECT_EN
            ru = u & ~m_pu;
            rd = d & ~m_pd;
`else
            ru = u;
            rd = d;
`endif
            m_pu = u;
            m_pd = d;
            m_alarm = 1'b0;
            if (ru && !rd) begin
                if (m_cnt == MAX) m_alarm = 1'b1;
                else m_cnt++;
            end else if (rd && !ru) begin
                if (m_cnt == 0) m_alarm = 1'b1;
                else m_cnt--;
            end
        end
    endtask

    task automatic step(input logic r, input logic u, input logic d);
        exp_t e;
        logic [2:0] c3;
        reset = r; up = u; down = d;
        model(r, u, d);
        c3 = m_cnt[2:0];
        e.cnt   = c3;
        e.full  = (m_cnt == MAX);
        e.empty = (m_cnt == 0);
        e.alarm = m_alarm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            check("pcount", pcount, e.cnt);
            check("full",   {2'b0, full_flag},  {2'b0, e.full});
            check("empty",  {2'b0, empty_flag}, {2'b0, e.empty});
            check("alarm",  {2'b0, alarm_flag}, {2'b0, e.alarm});
        end
    endtask

    initial begin
        reset = 1'b0; up = 1'b0; down = 1'b0;
        @(negedge clk);
        step(1, 0, 0);
        repeat (8) step(0, 0, 0);
        repeat (8) step(0, 1, 0);
        repeat (8) step(0, 0, 1);
        repeat (8) step(0, 1, 1);
        repeat (4) step(0, 1, 0);
        step(1, 1, 0);
        step(0, 0, 0);
        repeat (5) step(0, 1, 0);
        step(0, 0, 0);
        repeat (3) begin
            step(0, 1, 0);
            step(0, 0, 0);
        end
        repeat (3) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
        repeat (3) step(0, 0, 1);
        repeat (60) step(($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, 1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
